instruction_fetch_stage: RTL and testbench

//   Fetch stage directly downstream of the program counter. Presents the current PC
//   to a synchronous instruction ROM and pulses the PC increment enable for each

---
 rtl/instruction_fetch_stage_if.sv | 44 ++++
 rtl/instruction_fetch_stage.sv | 139 +++++++++++++
 tb/tb_instruction_fetch_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage_if
//   Bundles every bus the fetch stage talks on: the program counter link
//   (pc / pc_inc), the synchronous instruction ROM port (imem_*), the branch
//   flush input and the valid/ready hand-off to decode (instr_*).
//
//   Handshake (decode side): an entry moves from fetch to decode on a rising
//   clock edge where instr_valid && instr_ready are both 1.  instr_valid never
//   depends on instr_ready.  Once raised, instr_valid and its payload hold
//   until accepted, except that flush withdraws them.
//
//   Modports
//     master : the fetch stage itself
//     slave  : the surrounding system (PC counter, ROM, decode)
//   state_dbg exposes the fetch FSM state (0 BOOT, 1 RUN, 2 FLUSH).
// ---------------------------------------------------------------------------
interface instruction_fetch_stage_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic [PC_W-1:0]    pc;
    logic               pc_inc;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rd_en;
    logic [INSTR_W-1:0] imem_rdata;
    logic               flush;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic [1:0]         state_dbg;

    modport master (
        input  pc, imem_rdata, flush, instr_ready,
        output pc_inc, imem_addr, imem_rd_en, instr_valid, instr, instr_pc,
               state_dbg
    );

    modport slave (
        output pc, imem_rdata, flush, instr_ready,
        input  pc_inc, imem_addr, imem_rd_en, instr_valid, instr, instr_pc,
               state_dbg
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
//   Fetch stage sitting right after the program counter.  Drives the current
//   PC to a synchronous ROM, pulses pc_inc for every read it issues, buffers
//   the returned {pc, instruction} pairs in a DEPTH-entry FIFO and hands them
//   to decode over valid/ready.  flush throws away everything buffered or in
//   flight (the PC is reloaded externally).
//
//   Ports
//     clk      : clock, rising edge
//     reset_n  : asynchronous reset, active low
//     bus      : instruction_fetch_stage_if.master (pc, pc_inc, imem_addr,
//                imem_rd_en, imem_rdata, flush, instr_valid, instr_ready,
//                instr, instr_pc, state_dbg)
// ---------------------------------------------------------------------------
module instruction_fetch_stage #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    instruction_fetch_stage_if.master     bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               inflight;
    logic [PC_W-1:0]    req_pc;
    logic [INSTR_W-1:0] hold_instr;
    logic [PC_W-1:0]    hold_pc;

    logic               head_valid;
    logic               pop;
    logic               push;
    logic               issue;
    logic [OCC_W-1:0]   occupancy;

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   if (bus.flush) state_d = ST_FLUSH;
            ST_FLUSH: state_d = bus.flush ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_BOOT;
        else          state_q <= state_d;
    end

    // ---------------- issue / credit ----------------
    // Occupancy counts buffered entries plus the read still in the ROM, minus
    // the entry leaving this cycle.  Issuing only while it is below DEPTH means
    // every response has a free slot when it lands.
    always_comb begin
        head_valid = (count != '0);
        pop        = head_valid && !bus.flush && bus.instr_ready;
        push       = inflight && !bus.flush;
        occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight}
                   - {{CNT_W{1'b0}}, pop};
        issue      = (state_q == ST_RUN) && !bus.flush
                   && (occupancy < OCC_W'(DEPTH));
    end

    assign bus.imem_addr   = bus.pc;
    assign bus.imem_rd_en  = issue;
    assign bus.pc_inc      = issue;
    assign bus.instr_valid = head_valid && !bus.flush;
    // When nothing valid is shown, replay the last shown entry instead of
    // whatever stale data sits at the read pointer.
    assign bus.instr       = bus.instr_valid ? instr_mem[rd_ptr] : hold_instr;
    assign bus.instr_pc    = bus.instr_valid ? pc_mem[rd_ptr]    : hold_pc;
    assign bus.state_dbg   = state_q;

    // ---------------- control state ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            inflight   <= 1'b0;
            req_pc     <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else begin
            // issue is forced low under flush, which also cancels the read
            // currently in the ROM.
            inflight <= issue;
            if (issue) req_pc <= bus.pc;
            if (bus.instr_valid) begin
                hold_instr <= instr_mem[rd_ptr];
                hold_pc    <= pc_mem[rd_ptr];
            end
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset: outputs only read it while an entry is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= bus.imem_rdata;
        end
    end

    // The credit rule must make a push into a full buffer impossible.
    assert property (@(posedge clk) disable iff (!reset_n)
        !(push && (count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;
    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        instr_ready;
    logic        load_en;
    logic [7:0]  load_val;
    logic [7:0]  pc_q;
    logic [15:0] rom_q;

    int tests_run    = 0;
    int tests_failed = 0;
    int pops         = 0;

    logic [23:0] exp_q[$];
    logic [15:0] last_instr;
    logic [7:0]  last_pc;

    instruction_fetch_stage_if #(.PC_W(8), .INSTR_W(16)) bus ();

    instruction_fetch_stage #(.PC_W(8), .INSTR_W(16), .DEPTH(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.pc          = pc_q;
    assign bus.imem_rdata  = rom_q;
    assign bus.flush       = flush;
    assign bus.instr_ready = instr_ready;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- environment models ----------------
    function automatic logic [15:0] rom(input logic [7:0] a);
        return 16'hA000 + {8'h00, a};
    endfunction

    // Program counter: async reset, external reload, increments on pc_inc.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)         pc_q <= 8'h00;
        else if (load_en)     pc_q <= load_val;
        else if (bus.pc_inc)  pc_q <= pc_q + 8'h01;
    end

    // Synchronous ROM: data valid one cycle after the read strobe.
    initial rom_q = 16'h0000;
    always @(posedge clk) begin
        if (bus.imem_rd_en) rom_q <= rom(bus.imem_addr);
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            last_instr = 16'h0000;
            last_pc    = 8'h00;
        end else begin
            tests_run++;
            if (bus.imem_addr !== pc_q || bus.pc_inc !== bus.imem_rd_en) begin
                tests_failed++;
                $display("FAIL addr_strobe: addr=%0h pc_inc=%0b rd_en=%0b expected addr=%0h pc_inc==rd_en",
                         bus.imem_addr, bus.pc_inc, bus.imem_rd_en, pc_q);
            end
            if (flush) begin
                tests_run++;
                if (bus.instr_valid !== 1'b0 || bus.pc_inc !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL flush_quiet: valid=%0b pc_inc=%0b expected 0 0",
                             bus.instr_valid, bus.pc_inc);
                end
                exp_q.delete();
            end else begin
                if (bus.instr_valid === 1'b1 && instr_ready) begin
                    tests_run++;
                    pops++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL sb_extra: got pc=%0h instr=%0h expected no entry",
                                 bus.instr_pc, bus.instr);
                    end else begin
                        logic [23:0] e;
                        e = exp_q.pop_front();
                        if ({bus.instr_pc, bus.instr} !== e) begin
                            tests_failed++;
                            $display("FAIL sb_data: got pc=%0h instr=%0h expected pc=%0h instr=%0h",
                                     bus.instr_pc, bus.instr, e[23:16], e[15:0]);
                        end
                    end
                end
                if (bus.pc_inc === 1'b1) exp_q.push_back({pc_q, rom(pc_q)});
            end
            if (bus.instr_valid === 1'b1) begin
                last_instr = bus.instr;
                last_pc    = bus.instr_pc;
            end else begin
                tests_run++;
                if (bus.instr !== last_instr || bus.instr_pc !== last_pc) begin
                    tests_failed++;
                    $display("FAIL hold: got pc=%0h instr=%0h expected pc=%0h instr=%0h",
                             bus.instr_pc, bus.instr, last_pc, last_instr);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Flush for one cycle while the PC counter reloads to target.
    // Returns 1 time unit into the cycle after the flush cycle.
    task automatic flush_reload(input logic [7:0] target);
        next_cycle();
        flush    = 1'b1;
        load_en  = 1'b1;
        load_val = target;
        next_cycle();
        flush   = 1'b0;
        load_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n     = 1'b0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        load_en     = 1'b0;
        load_val    = 8'h00;
        #12;
        tests_run++;
        if ({bus.pc_inc, bus.imem_rd_en, bus.instr_valid, bus.instr, bus.instr_pc} !== 27'd0
            || bus.state_dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got inc=%0b rd=%0b v=%0b instr=%0h pc=%0h st=%0d expected all 0",
                     bus.pc_inc, bus.imem_rd_en, bus.instr_valid, bus.instr, bus.instr_pc, bus.state_dbg);
        end
        #10;
        reset_n = 1'b1;
        #1;
        tests_run++;
        if (bus.imem_rd_en !== 1'b0 || bus.pc_inc !== 1'b0) begin
            tests_failed++;
            $display("FAIL boot_no_issue: got rd=%0b inc=%0b expected 0 0", bus.imem_rd_en, bus.pc_inc);
        end
        @(negedge clk);
        tests_run++;
        if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL first_issue: got rd=%0b addr=%0h expected 1 00", bus.imem_rd_en, bus.imem_addr);
        end
    endtask

    task automatic test_backpressure();
        int issues = 1;
        int start;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.pc_inc === 1'b1) issues++;
        end
        tests_run++;
        if (issues != 2) begin
            tests_failed++;
            $display("FAIL bp_issues: got %0d expected 2", issues);
        end
        tests_run++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 16'hA000 || bus.instr_pc !== 8'h00) begin
            tests_failed++;
            $display("FAIL bp_head: got v=%0b instr=%0h pc=%0h expected 1 A000 00",
                     bus.instr_valid, bus.instr, bus.instr_pc);
        end
        next_cycle();
        instr_ready = 1'b1;
        start = pops;
        repeat (6) @(negedge clk);
        #1;
        tests_run++;
        if (pops - start != 6) begin
            tests_failed++;
            $display("FAIL bp_drain_rate: got %0d pops expected 6", pops - start);
        end
        next_cycle();
        instr_ready = 1'b0;
    endtask

    task automatic test_streaming();
        instr_ready = 1'b1;
        flush_reload(8'h10);
        @(negedge clk);
        tests_run++;
        if (bus.instr_valid !== 1'b0 || bus.pc_inc !== 1'b0 || bus.state_dbg !== 2'd2) begin
            tests_failed++;
            $display("FAIL stream_flush_state: got v=%0b inc=%0b st=%0d expected 0 0 2",
                     bus.instr_valid, bus.pc_inc, bus.state_dbg);
        end
        @(negedge clk);
        tests_run++;
        if (bus.pc_inc !== 1'b1 || bus.imem_addr !== 8'h10) begin
            tests_failed++;
            $display("FAIL stream_issue: got inc=%0b addr=%0h expected 1 10", bus.pc_inc, bus.imem_addr);
        end
        @(negedge clk);
        tests_run++;
        if (bus.instr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_latency_early: got v=%0b expected 0", bus.instr_valid);
        end
        // Back-to-back: one entry per cycle, PCs consecutive, count held at 1
        // by simultaneous push and pop.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] ep;
            @(negedge clk);
            ep = 8'h10 + 8'(i);
            tests_run++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== ep || bus.instr !== rom(ep)) begin
                tests_failed++;
                $display("FAIL stream_b2b: got v=%0b pc=%0h instr=%0h expected 1 %0h %0h",
                         bus.instr_valid, bus.instr_pc, bus.instr, ep, rom(ep));
            end
        end
    endtask

    task automatic test_flush();
        int waited = 0;
        instr_ready = 1'b0;
        flush_reload(8'h20);
        repeat (3) @(negedge clk);
        // One entry buffered (0x20) and one read in flight (0x21) now.
        next_cycle();
        flush    = 1'b1;
        load_en  = 1'b1;
        load_val = 8'h40;
        @(negedge clk);
        tests_run++;
        if (bus.instr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_valid: got v=%0b expected 0", bus.instr_valid);
        end
        next_cycle();
        flush   = 1'b0;
        load_en = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.instr_valid !== 1'b0 || bus.pc_inc !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_next: got v=%0b inc=%0b expected 0 0", bus.instr_valid, bus.pc_inc);
        end
        @(negedge clk);
        tests_run++;
        if (bus.pc_inc !== 1'b1 || bus.imem_addr !== 8'h40) begin
            tests_failed++;
            $display("FAIL flush_refetch: got inc=%0b addr=%0h expected 1 40", bus.pc_inc, bus.imem_addr);
        end
        next_cycle();
        instr_ready = 1'b1;
        @(negedge clk);
        while (bus.instr_valid !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h40 || bus.instr !== 16'hA040) begin
            tests_failed++;
            $display("FAIL flush_first: got v=%0b pc=%0h instr=%0h expected 1 40 A040",
                     bus.instr_valid, bus.instr_pc, bus.instr);
        end
    endtask

    task automatic test_random_ready();
        int start = pops;
        for (int i = 0; i < 60; i++) begin
            next_cycle();
            instr_ready = 1'($urandom_range(0, 1));
        end
        next_cycle();
        instr_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        tests_run++;
        if (pops - start < 20) begin
            tests_failed++;
            $display("FAIL random_progress: got %0d pops expected at least 20", pops - start);
        end
    endtask

    task automatic test_async_reset();
        instr_ready = 1'b1;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.pc_inc, bus.imem_rd_en, bus.instr_valid, bus.instr, bus.instr_pc} !== 27'd0
            || bus.state_dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got inc=%0b rd=%0b v=%0b instr=%0h pc=%0h st=%0d expected all 0",
                     bus.pc_inc, bus.imem_rd_en, bus.instr_valid, bus.instr, bus.instr_pc, bus.state_dbg);
        end
        #12;
        reset_n = 1'b1;
        #1;
        tests_run++;
        if (bus.imem_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_boot: got rd=%0b expected 0", bus.imem_rd_en);
        end
        @(negedge clk);
        tests_run++;
        if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_restart: got rd=%0b addr=%0h expected 1 00", bus.imem_rd_en, bus.imem_addr);
        end
        // PC wrap: 0xFD .. 0x02 must stream without a stall.
        flush_reload(8'hFD);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] ep;
            @(negedge clk);
            ep = 8'hFD + 8'(i);
            tests_run++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== ep || bus.instr !== rom(ep)) begin
                tests_failed++;
                $display("FAIL pc_wrap: got v=%0b pc=%0h instr=%0h expected 1 %0h %0h",
                         bus.instr_valid, bus.instr_pc, bus.instr, ep, rom(ep));
            end
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_streaming();
        test_flush();
        test_random_ready();
        test_async_reset();
        next_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
